// File: rtl/btn_pkg.sv
// Shared types and sizing helpers for the push-button debounce array.
package btn_pkg;

  // Per-channel press tracking state. LATCHED is only reachable when
  // auto-repeat is disabled.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESS   = 2'd1,
    ST_REPEAT  = 2'd2,
    ST_LATCHED = 2'd3
  } btn_state_e;

  // Width of the hold/repeat counter: wide enough to hold the larger of the
  // two terminal counts.
  function automatic int hold_cnt_width(input int hold_ticks, input int repeat_ticks);
    int m;
    m = (hold_ticks > repeat_ticks) ? hold_ticks : repeat_ticks;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

  // Width of the sample-tick divider counter (sample_div >= 2).
  function automatic int div_cnt_width(input int sample_div);
    return (sample_div < 2) ? 1 : $clog2(sample_div);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-FF synchroniser, sample history, acceptance logic,
// press-tracking FSM and hold/repeat counter. All outputs are registered.
//
//   state      | meaning
//   -----------+----------------------------------------------------------
//   ST_IDLE    | button released (level=0), hold counter held at 0
//   ST_PRESS   | accepted press, counting ticks towards long-press
//   ST_REPEAT  | long-press reported, counting ticks between repeat pulses
//   ST_LATCHED | long-press reported, repeat disabled, waiting for release
module debounce_channel
  import btn_pkg::*;
#(
  parameter int STABLE_N     = 3,
  parameter int HOLD_TICKS   = 64,
  parameter int REPEAT_TICKS = 16
) (
  input  logic clk,
  input  logic buttom_rst,
  input  logic btn_raw,
  input  logic tick,
  output logic level,
  output logic pos,
  output logic neg,
  output logic long_p,
  output logic rpt
);

  localparam int CW = hold_cnt_width(HOLD_TICKS, REPEAT_TICKS);
  // Only the STABLE_N-1 previous samples are needed: the window is
  // completed by the sample arriving on the current tick.
  localparam int HW = STABLE_N - 1;
  localparam logic [CW-1:0] HOLD_C   = CW'(HOLD_TICKS);
  localparam logic [CW-1:0] REPEAT_C = CW'(REPEAT_TICKS);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  logic          sync1_q, sync2_q;
  logic [HW-1:0] hist_q;
  logic          win_hi, win_lo;
  logic          accept_press, accept_rel;

  btn_state_e    state_q, state_d;
  logic [CW-1:0] hold_cnt_q, hold_cnt_d, cnt_inc;

  logic level_q, level_d;
  logic pos_q, pos_d;
  logic neg_q, neg_d;
  logic long_q, long_d;
  logic rpt_q, rpt_d;

  // Synchronise the raw pin and shift the synchronised value into the history on each tick.
  always_ff @(posedge clk or negedge buttom_rst) begin
    if (!buttom_rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      if (tick) begin
        hist_q <= HW'({hist_q, sync2_q});
      end
    end
  end

  // Window qualification: new sample plus history all equal and different from the level.
  always_comb begin
    win_hi       = sync2_q & (&hist_q);
    win_lo       = ~sync2_q & ~(|hist_q);
    accept_press = tick & win_hi & ~level_q;
    accept_rel   = tick & win_lo & level_q;
    cnt_inc      = (hold_cnt_q == CNT_MAX) ? hold_cnt_q : hold_cnt_q + CW'(1);
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge buttom_rst) begin
    if (!buttom_rst) begin
      state_q    <= ST_IDLE;
      hold_cnt_q <= '0;
      level_q    <= 1'b0;
      pos_q      <= 1'b0;
      neg_q      <= 1'b0;
      long_q     <= 1'b0;
      rpt_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      level_q    <= level_d;
      pos_q      <= pos_d;
      neg_q      <= neg_d;
      long_q     <= long_d;
      rpt_q      <= rpt_d;
    end
  end

  // Next state and hold counter; an accepted release overrides everything.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      ST_IDLE: begin
        hold_cnt_d = '0;
        if (accept_press) begin
          state_d = ST_PRESS;
        end
      end
      ST_PRESS: begin
        if (tick) begin
          if (cnt_inc == HOLD_C) begin
            hold_cnt_d = '0;
            state_d    = (REPEAT_TICKS > 0) ? ST_REPEAT : ST_LATCHED;
          end else begin
            hold_cnt_d = cnt_inc;
          end
        end
      end
      ST_REPEAT: begin
        if (tick) begin
          hold_cnt_d = (cnt_inc == REPEAT_C) ? '0 : cnt_inc;
        end
      end
      ST_LATCHED: begin
        hold_cnt_d = '0;
      end
      default: begin
        state_d    = ST_IDLE;
        hold_cnt_d = '0;
      end
    endcase
    if (accept_rel) begin
      state_d    = ST_IDLE;
      hold_cnt_d = '0;
    end
  end

  // Pulse and level updates; release suppresses a same-tick long/repeat pulse.
  always_comb begin
    level_d = level_q;
    pos_d   = 1'b0;
    neg_d   = 1'b0;
    long_d  = 1'b0;
    rpt_d   = 1'b0;
    if (accept_press) begin
      level_d = 1'b1;
      pos_d   = 1'b1;
    end else if (accept_rel) begin
      level_d = 1'b0;
      neg_d   = 1'b1;
    end else if (tick) begin
      if ((state_q == ST_PRESS) && (cnt_inc == HOLD_C)) begin
        long_d = 1'b1;
      end
      if ((state_q == ST_REPEAT) && (cnt_inc == REPEAT_C)) begin
        rpt_d = 1'b1;
      end
    end
  end

  assign level  = level_q;
  assign pos    = pos_q;
  assign neg    = neg_q;
  assign long_p = long_q;
  assign rpt    = rpt_q;

endmodule

// File: rtl/button_debounce_array.sv
// Multi-channel button debounce with press/release/long-press/repeat pulses.
// A shared divider produces the sample tick used by every channel.
module button_debounce_array
  import btn_pkg::*;
#(
  parameter int N_CH         = 5,
  parameter int SAMPLE_DIV   = 8,
  parameter int STABLE_N     = 3,
  parameter int HOLD_TICKS   = 64,
  parameter int REPEAT_TICKS = 16
) (
  input  logic            clk,
  input  logic            buttom_rst,
  input  logic [N_CH-1:0] btn_raw,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] pos,
  output logic [N_CH-1:0] neg,
  output logic [N_CH-1:0] long_p,
  output logic [N_CH-1:0] rpt,
  output logic            tick
);

  localparam int DW = div_cnt_width(SAMPLE_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(SAMPLE_DIV - 1);

  logic [DW-1:0] div_cnt_q, div_cnt_d;

  // Divider next value: count up and wrap at SAMPLE_DIV-1.
  always_comb begin
    div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DW'(1);
  end

  // Divider register; cleared by reset so the first tick lands SAMPLE_DIV clocks after release.
  always_ff @(posedge clk or negedge buttom_rst) begin
    if (!buttom_rst) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

  assign tick = (div_cnt_q == DIV_LAST);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    debounce_channel #(
      .STABLE_N    (STABLE_N),
      .HOLD_TICKS  (HOLD_TICKS),
      .REPEAT_TICKS(REPEAT_TICKS)
    ) u_ch (
      .clk       (clk),
      .buttom_rst(buttom_rst),
      .btn_raw   (btn_raw[g]),
      .tick      (tick),
      .level     (level[g]),
      .pos       (pos[g]),
      .neg       (neg[g]),
      .long_p    (long_p[g]),
      .rpt       (rpt[g])
    );
  end

endmodule

// File: tb/tb_button_debounce_array.sv
// Directed bench for button_debounce_array (SAMPLE_DIV=4, STABLE_N=3,
// HOLD_TICKS=5, REPEAT_TICKS=2) plus a second instance with repeat disabled.
module tb_button_debounce_array;

  localparam int N = 5;

  logic         clk = 1'b0;
  logic         buttom_rst = 1'b0;
  logic [N-1:0] btn_raw = '0;
  logic [N-1:0] btn_raw1 = '0;
  logic [N-1:0] level, pos, neg, long_p, rpt;
  logic         tick;
  logic [N-1:0] level1, pos1, neg1, long1, rpt1;
  logic         tick1;

  always #5 clk = ~clk;

  button_debounce_array #(
    .N_CH(N), .SAMPLE_DIV(4), .STABLE_N(3), .HOLD_TICKS(5), .REPEAT_TICKS(2)
  ) dut (
    .clk(clk), .buttom_rst(buttom_rst), .btn_raw(btn_raw),
    .level(level), .pos(pos), .neg(neg), .long_p(long_p), .rpt(rpt), .tick(tick)
  );

  button_debounce_array #(
    .N_CH(N), .SAMPLE_DIV(4), .STABLE_N(3), .HOLD_TICKS(5), .REPEAT_TICKS(0)
  ) dut_norpt (
    .clk(clk), .buttom_rst(buttom_rst), .btn_raw(btn_raw1),
    .level(level1), .pos(pos1), .neg(neg1), .long_p(long1), .rpt(rpt1), .tick(tick1)
  );

  int checks = 0;
  int errors = 0;

  // Event recorder, sampled on the falling edge.
  int cyc = 0;
  int pos_cnt[N]   = '{default: 0};
  int neg_cnt[N]   = '{default: 0};
  int long_cnt[N]  = '{default: 0};
  int rpt_cnt[N]   = '{default: 0};
  int pos_cyc[N]   = '{default: 0};
  int neg_cyc[N]   = '{default: 0};
  int long_cyc[N]  = '{default: 0};
  int rpt_first[N] = '{default: 0};
  int rpt_last[N]  = '{default: 0};
  int rpt_prev[N]  = '{default: 0};
  int tick_cnt = 0, tick_cyc = 0;
  int d1_pos = 0, d1_neg = 0, d1_long = 0, d1_rpt = 0;
  int excl_viol = 0, lvl_viol = 0;
  logic [N-1:0] prev_level = '0;
  logic prev_tick = 1'b0, prev_rst = 1'b0;

  always @(negedge clk) begin
    cyc        <= cyc + 1;
    prev_level <= level;
    prev_tick  <= tick;
    prev_rst   <= buttom_rst;
    if (tick) begin
      tick_cnt <= tick_cnt + 1;
      tick_cyc <= cyc + 1;
    end
    for (int i = 0; i < N; i++) begin
      if (pos[i])    begin pos_cnt[i]  <= pos_cnt[i] + 1;  pos_cyc[i]  <= cyc + 1; end
      if (neg[i])    begin neg_cnt[i]  <= neg_cnt[i] + 1;  neg_cyc[i]  <= cyc + 1; end
      if (long_p[i]) begin long_cnt[i] <= long_cnt[i] + 1; long_cyc[i] <= cyc + 1; end
      if (rpt[i]) begin
        rpt_cnt[i]  <= rpt_cnt[i] + 1;
        rpt_prev[i] <= rpt_last[i];
        rpt_last[i] <= cyc + 1;
        if (rpt_cnt[i] == 0) rpt_first[i] <= cyc + 1;
      end
      if ((pos[i] && neg[i]) || (pos[i] && (long_p[i] || rpt[i])))
        excl_viol <= excl_viol + 1;
      if (pos[i] && !(level[i] && !prev_level[i])) excl_viol <= excl_viol + 1;
      if (neg[i] && !(!level[i] && prev_level[i])) excl_viol <= excl_viol + 1;
      if (buttom_rst && prev_rst && (level[i] !== prev_level[i]) && !prev_tick)
        lvl_viol <= lvl_viol + 1;
    end
    if (pos1[0])  d1_pos  <= d1_pos + 1;
    if (neg1[0])  d1_neg  <= d1_neg + 1;
    if (long1[0]) d1_long <= d1_long + 1;
    if (rpt1[0])  d1_rpt  <= d1_rpt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance n clocks; returns 2 time units after a rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  int t, b0, b1, b2, b3, b4, bn, bl, rc;

  initial begin
    // Reset state
    step(3);
    check("rst_level", 32'(level), 0);
    check("rst_pos", 32'(pos), 0);
    check("rst_neg", 32'(neg), 0);
    check("rst_long", 32'(long_p), 0);
    check("rst_rpt", 32'(rpt), 0);
    check("rst_tick", 32'(tick), 0);

    // Divider: first tick 4 clocks after reset release, one clock wide
    buttom_rst = 1'b1;
    t  = cyc;
    b0 = tick_cnt;
    step(6);
    check("first_tick_cnt", 32'(tick_cnt - b0), 1);
    check("first_tick_lat", 32'(tick_cyc - t), 4);

    // Clean press on channel 0
    b0 = pos_cnt[0];
    b1 = pos_cnt[1] + pos_cnt[2] + pos_cnt[3] + pos_cnt[4];
    btn_raw[0] = 1'b1;
    t = cyc;
    step(16);
    check("clean_pos_cnt", 32'(pos_cnt[0] - b0), 1);
    check("clean_pos_lat_ok", 32'((pos_cyc[0] - t) >= 12 && (pos_cyc[0] - t) <= 15), 1);
    check("clean_level", 32'(level[0]), 1);
    check("clean_others", 32'(pos_cnt[1] + pos_cnt[2] + pos_cnt[3] + pos_cnt[4] - b1), 0);
    bn = neg_cnt[0];
    bl = long_cnt[0];
    btn_raw[0] = 1'b0;
    step(18);
    check("clean_neg_cnt", 32'(neg_cnt[0] - bn), 1);
    check("clean_no_long", 32'(long_cnt[0] - bl), 0);
    check("clean_level_rel", 32'(level[0]), 0);

    // Bounce on channel 1: 3-clock toggles never give 3 equal samples
    b1 = pos_cnt[1];
    bn = neg_cnt[1];
    for (int k = 0; k < 42; k++) begin
      btn_raw[1] = ((k / 3) % 2 == 0);
      step(1);
    end
    check("bounce_no_pos", 32'(pos_cnt[1] - b1), 0);
    check("bounce_level_lo", 32'(level[1]), 0);
    btn_raw[1] = 1'b1;
    t = cyc;
    step(16);
    check("bounce_pos_cnt", 32'(pos_cnt[1] - b1), 1);
    check("bounce_neg_cnt", 32'(neg_cnt[1] - bn), 0);
    check("bounce_after_settle", 32'(pos_cyc[1] > t), 1);
    check("bounce_level_hi", 32'(level[1]), 1);
    btn_raw[1] = 1'b0;
    step(18);
    check("bounce_rel_neg", 32'(neg_cnt[1] - bn), 1);

    // Long press and auto-repeat on channel 2
    b2 = pos_cnt[2];
    bl = long_cnt[2];
    rc = rpt_cnt[2];
    bn = neg_cnt[2];
    btn_raw[2] = 1'b1;
    step(16);
    check("long_pos_cnt", 32'(pos_cnt[2] - b2), 1);
    step(60);
    check("long_cnt", 32'(long_cnt[2] - bl), 1);
    check("long_delay", 32'(long_cyc[2] - pos_cyc[2]), 20);
    check("rpt_first_gap", 32'(rpt_first[2] - long_cyc[2]), 8);
    check("rpt_period", 32'(rpt_last[2] - rpt_prev[2]), 8);
    check("rpt_count_ge2", 32'((rpt_cnt[2] - rc) >= 2), 1);
    btn_raw[2] = 1'b0;
    step(20);
    check("long_neg_cnt", 32'(neg_cnt[2] - bn), 1);
    check("rpt_before_neg", 32'(rpt_last[2] < neg_cyc[2]), 1);
    rc = rpt_cnt[2];
    step(20);
    check("rpt_after_neg", 32'(rpt_cnt[2] - rc), 0);
    check("long_level_rel", 32'(level[2]), 0);

    // Repeat disabled instance: hold 100 clocks
    btn_raw1[0] = 1'b1;
    step(100);
    check("norpt_pos", 32'(d1_pos), 1);
    check("norpt_long", 32'(d1_long), 1);
    check("norpt_rpt", 32'(d1_rpt), 0);
    check("norpt_level", 32'(level1[0]), 1);
    btn_raw1[0] = 1'b0;
    step(20);
    check("norpt_neg", 32'(d1_neg), 1);
    check("norpt_rpt_end", 32'(d1_rpt), 0);
    check("norpt_long_end", 32'(d1_long), 1);

    // Reset during REPEAT with channel 2 held
    bl = long_cnt[2];
    btn_raw[2] = 1'b1;
    step(44);
    check("mid_in_repeat", 32'(long_cnt[2] - bl), 1);
    buttom_rst = 1'b0;
    #1;
    check("mid_rst_level", 32'(level), 0);
    check("mid_rst_pos", 32'(pos), 0);
    check("mid_rst_neg", 32'(neg), 0);
    check("mid_rst_long", 32'(long_p), 0);
    check("mid_rst_rpt", 32'(rpt), 0);
    check("mid_rst_tick", 32'(tick), 0);
    step(3);
    b2 = pos_cnt[2];
    buttom_rst = 1'b1;
    t = cyc;
    step(20);
    check("mid_repos_cnt", 32'(pos_cnt[2] - b2), 1);
    check("mid_repos_lat_ok", 32'((pos_cyc[2] - t) <= 19), 1);
    check("mid_repos_lat", 32'(pos_cyc[2] - t), 13);
    btn_raw[2] = 1'b0;
    step(30);

    // Simultaneous presses on 0 and 4, 3-clock glitch on 3
    b0 = pos_cnt[0];
    b4 = pos_cnt[4];
    b3 = pos_cnt[3];
    bn = neg_cnt[3];
    btn_raw[0] = 1'b1;
    btn_raw[4] = 1'b1;
    btn_raw[3] = 1'b1;
    step(3);
    btn_raw[3] = 1'b0;
    step(13);
    check("sim_pos0", 32'(pos_cnt[0] - b0), 1);
    check("sim_pos4", 32'(pos_cnt[4] - b4), 1);
    check("sim_same_clk", 32'(pos_cyc[0] == pos_cyc[4]), 1);
    check("glitch_pos3", 32'(pos_cnt[3] - b3), 0);
    check("glitch_neg3", 32'(neg_cnt[3] - bn), 0);
    check("glitch_level3", 32'(level[3]), 0);
    b0 = neg_cnt[0];
    b4 = neg_cnt[4];
    btn_raw[0] = 1'b0;
    btn_raw[4] = 1'b0;
    step(18);
    check("sim_neg0", 32'(neg_cnt[0] - b0), 1);
    check("sim_neg4", 32'(neg_cnt[4] - b4), 1);
    check("sim_neg_same_clk", 32'(neg_cyc[0] == neg_cyc[4]), 1);

    // Whole-run invariants
    check("pulse_exclusivity", 32'(excl_viol), 0);
    check("level_only_on_tick", 32'(lvl_viol), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
